// File: rtl/pio_buffer_pkg.sv
// Shared definitions for the PIO segment filler.
// Contents:
//   ST_*        status codes presented to the ARM on pio_out
//   fillState_t top-level FSM states
//   clog2       ceiling log2, used to size indices and counters
package pio_buffer_pkg;

    localparam int ST_CHUNK    = 3;
    localparam int ST_READY    = 6;
    localparam int ST_SEG_DONE = 7;
    localparam int ST_ERROR    = 8;

    typedef enum logic [1:0] {
        RECV,
        WRITE,
        WAIT
    } fillState_t;

    function automatic int clog2(input int value);
        int result;
        int remaining;
        result    = 0;
        remaining = value - 1;
        while (remaining > 0) begin
            result    = result + 1;
            remaining = remaining >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/pio_chunk_assembler.sv
// Reassembles tagged PIO chunks into one DATA_W word.
// Ports:
//   clock, reset_n  rising-edge clock, asynchronous active-low reset
//   pioIn           {tag, payload} word from the ARM (level-held)
//   enable          sample pioIn this cycle (top FSM is receiving)
//   clear           return the chunk index to 0
//   word            current word with this cycle's payload merged in
//   wordValid       final chunk accepted this cycle; word is complete
//   chunkAccepted   non-final chunk accepted this cycle
//   tagError        in-range tag that is neither expected nor the last accepted one
module pio_chunk_assembler
    import pio_buffer_pkg::*;
#(
    parameter int               DATA_W   = 32,
    parameter int               CHUNK_W  = 16,
    parameter int               TAG_W    = 16,
    parameter logic [TAG_W-1:0] TAG_BASE = TAG_W'(16'h0045)
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic [TAG_W+CHUNK_W-1:0] pioIn,
    input  logic                     enable,
    input  logic                     clear,
    output logic [DATA_W-1:0]        word,
    output logic                     wordValid,
    output logic                     chunkAccepted,
    output logic                     tagError
);

    localparam int CHUNKS = DATA_W / CHUNK_W;
    localparam int K_W    = clog2(CHUNKS);

    logic [K_W-1:0]     chunkIdx;
    logic [DATA_W-1:0]  wordReg;
    logic [TAG_W-1:0]   lastTag;
    logic               lastTagValid;
    logic [TAG_W-1:0]   tag;
    logic [TAG_W-1:0]   tagOffset;
    logic [CHUNK_W-1:0] payload;
    logic               tagMatch;
    logic               tagInRange;
    logic               tagIsLast;
    logic               finalChunk;

    assign tag        = pioIn[TAG_W+CHUNK_W-1:CHUNK_W];
    assign payload    = pioIn[CHUNK_W-1:0];
    // Tags below TAG_BASE wrap to large offsets and so fall out of range.
    assign tagOffset  = tag - TAG_BASE;
    assign tagInRange = tagOffset < TAG_W'(CHUNKS);
    assign tagMatch   = enable && (tagOffset == TAG_W'(chunkIdx));
    // A level-held chunk re-presents the tag just accepted; that is not an error.
    assign tagIsLast  = lastTagValid && (tag == lastTag);
    assign finalChunk = (chunkIdx == K_W'(CHUNKS - 1));

    assign wordValid     = tagMatch && finalChunk;
    assign chunkAccepted = tagMatch && !finalChunk;
    assign tagError      = enable && tagInRange && !tagMatch && !tagIsLast;

    // Chunk 0 lands in the most significant slice.
    always_comb begin
        word = wordReg;
        for (int i = 0; i < CHUNKS; i++) begin
            if (chunkIdx == K_W'(CHUNKS - 1 - i)) begin
                word[i*CHUNK_W +: CHUNK_W] = payload;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            chunkIdx     <= '0;
            wordReg      <= '0;
            lastTag      <= '0;
            lastTagValid <= 1'b0;
        end else if (clear) begin
            chunkIdx <= '0;
        end else if (tagMatch) begin
            wordReg      <= word;
            lastTag      <= tag;
            lastTagValid <= 1'b1;
            chunkIdx     <= finalChunk ? '0 : chunkIdx + 1'b1;
        end else if (tagError) begin
            // Discard the partial word; the ARM restarts from chunk 0.
            wordReg      <= '0;
            chunkIdx     <= '0;
            lastTagValid <= 1'b0;
        end
    end

endmodule

// File: rtl/pio_segment_filler.sv
// Fills a segmented block-RAM buffer from tagged PIO chunks sent by the ARM.
// Fills the whole buffer once after reset, then one segment per consumer request.
// Ports:
//   clock, reset_n   rising-edge clock, asynchronous active-low reset
//   pio_in           {tag, payload} from the ARM
//   pio_out          status code to the ARM (ready/chunk/segment done/error)
//   buf_addr         buffer write address
//   buf_data         buffer write data
//   buf_wren         write enable, held WRITE_CYCLES cycles per word
//   fill_request     consumer level request to refill the next segment
//   fill_ack         one-cycle pulse when a request is accepted
//   active_segment   one-hot segment being refilled, 0 when none
//   booting          high until the initial full-buffer fill completes
//   protocol_error   sticky out-of-order chunk indication
module pio_segment_filler
    import pio_buffer_pkg::*;
#(
    parameter int               DATA_W       = 32,
    parameter int               CHUNK_W      = 16,
    parameter int               TAG_W        = 16,
    parameter int               ADDR_W       = 8,
    parameter int               N_SEGMENTS   = 2,
    parameter int               WRITE_CYCLES = 3,
    parameter logic [TAG_W-1:0] TAG_BASE     = TAG_W'(16'h0045)
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic [TAG_W+CHUNK_W-1:0] pio_in,
    output logic [TAG_W+CHUNK_W-1:0] pio_out,
    output logic [ADDR_W-1:0]        buf_addr,
    output logic [DATA_W-1:0]        buf_data,
    output logic                     buf_wren,
    input  logic                     fill_request,
    output logic                     fill_ack,
    output logic [N_SEGMENTS-1:0]    active_segment,
    output logic                     booting,
    output logic                     protocol_error
);

    localparam int PIO_W = TAG_W + CHUNK_W;
    localparam int SEL_W = clog2(N_SEGMENTS);
    localparam int SEG_W = ADDR_W - SEL_W;
    localparam int CNT_W = clog2(WRITE_CYCLES + 1);

    fillState_t        state;
    logic [CNT_W-1:0]  writeCount;
    logic [DATA_W-1:0] assembledWord;
    logic              wordValid;
    logic              chunkAccepted;
    logic              tagError;
    logic              segmentEnd;
    logic              bufferEnd;

    pio_chunk_assembler #(
        .DATA_W   (DATA_W),
        .CHUNK_W  (CHUNK_W),
        .TAG_W    (TAG_W),
        .TAG_BASE (TAG_BASE)
    ) assembler (
        .clock         (clock),
        .reset_n       (reset_n),
        .pioIn         (pio_in),
        .enable        (state == RECV),
        .clear         (state != RECV),
        .word          (assembledWord),
        .wordValid     (wordValid),
        .chunkAccepted (chunkAccepted),
        .tagError      (tagError)
    );

    assign segmentEnd = &buf_addr[SEG_W-1:0];
    assign bufferEnd  = &buf_addr;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state          <= RECV;
            writeCount     <= '0;
            pio_out        <= PIO_W'(ST_READY);
            buf_addr       <= '0;
            buf_data       <= '0;
            buf_wren       <= 1'b0;
            fill_ack       <= 1'b0;
            active_segment <= '0;
            booting        <= 1'b1;
            protocol_error <= 1'b0;
        end else begin
            fill_ack <= 1'b0;
            case (state)
                RECV: begin
                    if (wordValid) begin
                        buf_data   <= assembledWord;
                        buf_wren   <= 1'b1;
                        writeCount <= CNT_W'(WRITE_CYCLES - 1);
                        state      <= WRITE;
                    end else if (chunkAccepted) begin
                        pio_out <= PIO_W'(ST_CHUNK);
                    end else if (tagError) begin
                        pio_out        <= PIO_W'(ST_ERROR);
                        protocol_error <= 1'b1;
                    end
                end
                WRITE: begin
                    if (writeCount != '0) begin
                        writeCount <= writeCount - 1'b1;
                    end else begin
                        buf_wren <= 1'b0;
                        buf_addr <= buf_addr + 1'b1;
                        if (bufferEnd) begin
                            booting        <= 1'b0;
                            active_segment <= '0;
                        end
                        // During boot only the very last address ends the fill.
                        if (segmentEnd && (!booting || bufferEnd)) begin
                            pio_out <= PIO_W'(ST_SEG_DONE);
                            state   <= WAIT;
                        end else begin
                            pio_out <= PIO_W'(ST_READY);
                            state   <= RECV;
                        end
                    end
                end
                WAIT: begin
                    if (fill_request) begin
                        fill_ack       <= 1'b1;
                        active_segment <= N_SEGMENTS'(1) << buf_addr[ADDR_W-1 -: SEL_W];
                        pio_out        <= PIO_W'(ST_READY);
                        state          <= RECV;
                    end
                end
                default: state <= RECV;
            endcase
        end
    end

endmodule

// File: tb/tb_pio_segment_filler.sv
// Directed testbench for pio_segment_filler: default configuration (dut0) and a
// 48-bit, four-segment configuration (dut1).
module tb_pio_segment_filler;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        reset_n;

    logic [31:0] pio0;
    logic [31:0] pioOut0;
    logic [7:0]  addr0;
    logic [31:0] data0;
    logic        wren0;
    logic        fillReq0;
    logic        fillAck0;
    logic [1:0]  seg0;
    logic        boot0;
    logic        err0;

    logic [31:0] pio1;
    logic [31:0] pioOut1;
    logic [7:0]  addr1;
    logic [47:0] data1;
    logic        wren1;
    logic        fillReq1;
    logic        fillAck1;
    logic [3:0]  seg1;
    logic        boot1;
    logic        err1;

    int nChecks   = 0;
    int nErrors   = 0;
    int ackCount0 = 0;

    pio_segment_filler dut0 (
        .clock          (clock),
        .reset_n        (reset_n),
        .pio_in         (pio0),
        .pio_out        (pioOut0),
        .buf_addr       (addr0),
        .buf_data       (data0),
        .buf_wren       (wren0),
        .fill_request   (fillReq0),
        .fill_ack       (fillAck0),
        .active_segment (seg0),
        .booting        (boot0),
        .protocol_error (err0)
    );

    pio_segment_filler #(
        .DATA_W     (48),
        .N_SEGMENTS (4)
    ) dut1 (
        .clock          (clock),
        .reset_n        (reset_n),
        .pio_in         (pio1),
        .pio_out        (pioOut1),
        .buf_addr       (addr1),
        .buf_data       (data1),
        .buf_wren       (wren1),
        .fill_request   (fillReq1),
        .fill_ack       (fillAck1),
        .active_segment (seg1),
        .booting        (boot1),
        .protocol_error (err1)
    );

    always @(posedge clock) begin
        if (fillAck0) ackCount0 <= ackCount0 + 1;
    end

    typedef struct {
        logic [31:0] pio;
        logic [31:0] expStatus;
        logic        expWren;
        logic [7:0]  expAddr;
        logic [31:0] expData;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        nChecks++;
        if (actual !== expected) begin
            nErrors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic doReset();
        reset_n  = 1'b0;
        pio0     = '0;
        pio1     = '0;
        fillReq0 = 1'b0;
        fillReq1 = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        reset_n = 1'b1;
    endtask

    function automatic logic [31:0] pioOutOf(input int sel);
        return (sel == 0) ? pioOut0 : pioOut1;
    endfunction

    function automatic logic wrenOf(input int sel);
        return (sel == 0) ? wren0 : wren1;
    endfunction

    function automatic logic [7:0] addrOf(input int sel);
        return (sel == 0) ? addr0 : addr1;
    endfunction

    function automatic logic [47:0] dataOf(input int sel);
        return (sel == 0) ? {16'h0, data0} : data1;
    endfunction

    task automatic setPio(input int sel, input logic [31:0] value);
        if (sel == 0) pio0 = value;
        else          pio1 = value;
    endtask

    // Called one cycle after the final chunk was presented.
    task automatic finishWrite(input int sel, input logic [47:0] w, input logic [7:0] a,
                               input logic [31:0] expStatus);
        int   wc;
        logic ok;
        wc = 0;
        ok = 1'b1;
        while (wrenOf(sel) && wc < 10) begin
            if (addrOf(sel) !== a || dataOf(sel) !== w) ok = 1'b0;
            wc++;
            tick();
        end
        check($sformatf("wren_cycles@%0d", a), 64'(wc), 64'd3);
        check($sformatf("write_addr_data@%0d", a), 64'(ok), 64'd1);
        check($sformatf("post_status@%0d", a), 64'(pioOutOf(sel)), 64'(expStatus));
    endtask

    task automatic sendWord(input int sel, input int nChunks, input logic [47:0] w,
                            input logic [7:0] a, input logic [31:0] expStatus);
        logic [15:0] tag;
        for (int c = 0; c < nChunks; c++) begin
            tag = 16'h0045 + 16'(c);
            setPio(sel, {tag, w[(nChunks-1-c)*16 +: 16]});
            tick();
            if (c < nChunks - 1) check("chunk_status", 64'(pioOutOf(sel)), 64'd3);
        end
        finishWrite(sel, w, a, expStatus);
    endtask

    task automatic checkResetValues0(input string tag);
        check({tag, "_pio_out"}, 64'(pioOut0), 64'd6);
        check({tag, "_addr"}, 64'(addr0), 64'd0);
        check({tag, "_data"}, 64'(data0), 64'd0);
        check({tag, "_wren"}, 64'(wren0), 64'd0);
        check({tag, "_ack"}, 64'(fillAck0), 64'd0);
        check({tag, "_segment"}, 64'(seg0), 64'd0);
        check({tag, "_booting"}, 64'(boot0), 64'd1);
        check({tag, "_error"}, 64'(err0), 64'd0);
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          wc;
        int          ackStart;
        logic [47:0] w;

        vecs[0]  = '{32'h0000_0000, 32'd6, 1'b0, 8'd0, 32'h0};
        vecs[1]  = '{32'h0047_1111, 32'd6, 1'b0, 8'd0, 32'h0};
        vecs[2]  = '{32'h0045_ABCD, 32'd3, 1'b0, 8'd0, 32'h0};
        vecs[3]  = '{32'h0045_ABCD, 32'd3, 1'b0, 8'd0, 32'h0};
        vecs[4]  = '{32'h0045_9999, 32'd3, 1'b0, 8'd0, 32'h0};
        vecs[5]  = '{32'h0047_0000, 32'd3, 1'b0, 8'd0, 32'h0};
        vecs[6]  = '{32'h0046_1234, 32'd3, 1'b1, 8'd0, 32'hABCD_1234};
        vecs[7]  = '{32'h0046_1234, 32'd3, 1'b1, 8'd0, 32'hABCD_1234};
        vecs[8]  = '{32'h0046_1234, 32'd3, 1'b1, 8'd0, 32'hABCD_1234};
        vecs[9]  = '{32'h0046_1234, 32'd6, 1'b0, 8'd1, 32'hABCD_1234};
        vecs[10] = '{32'h0046_5555, 32'd6, 1'b0, 8'd1, 32'hABCD_1234};
        vecs[11] = '{32'h0045_0F0F, 32'd3, 1'b0, 8'd1, 32'hABCD_1234};

        // Reset state and table vectors
        doReset();
        checkResetValues0("reset");
        for (int i = 0; i < 12; i++) begin
            pio0 = vecs[i].pio;
            tick();
            check($sformatf("vec%0d_status", i), 64'(pioOut0), 64'(vecs[i].expStatus));
            check($sformatf("vec%0d_wren", i), 64'(wren0), 64'(vecs[i].expWren));
            check($sformatf("vec%0d_addr", i), 64'(addr0), 64'(vecs[i].expAddr));
            check($sformatf("vec%0d_data", i), 64'(data0), 64'(vecs[i].expData));
            check($sformatf("vec%0d_error", i), 64'(err0), 64'd0);
        end

        // Level-held first chunk for 20 cycles, then the second chunk
        doReset();
        pio0 = 32'h0045_ABCD;
        wc   = 0;
        repeat (20) begin
            tick();
            if (wren0) wc++;
        end
        check("hold_wren_cycles", 64'(wc), 64'd0);
        check("hold_status", 64'(pioOut0), 64'd3);
        pio0 = 32'h0046_1234;
        tick();
        finishWrite(0, 48'hABCD_1234, 8'd0, 32'd6);

        // Out-of-order chunk right after reset
        doReset();
        pio0 = 32'h0046_7777;
        tick();
        check("err_flag", 64'(err0), 64'd1);
        check("err_status", 64'(pioOut0), 64'd8);
        check("err_wren", 64'(wren0), 64'd0);
        pio0 = 32'h0045_1111;
        tick();
        check("err_resend_status", 64'(pioOut0), 64'd3);
        check("err_sticky", 64'(err0), 64'd1);
        pio0 = 32'h0046_2222;
        tick();
        finishWrite(0, 48'h1111_2222, 8'd0, 32'd6);
        check("err_booting", 64'(boot0), 64'd1);

        // Boot fill with fill_request raised during boot
        doReset();
        ackStart = ackCount0;
        fillReq0 = 1'b1;
        for (int i = 0; i < 256; i++) begin
            if (i == 200) fillReq0 = 1'b0;
            if (i == 128) check("boot_midway_booting", 64'(boot0), 64'd1);
            w = {16'h0, 8'(i), 8'(~i), 8'(i + 1), 8'(i ^ 8'h5A)};
            sendWord(0, 2, w, 8'(i), (i == 255) ? 32'd7 : 32'd6);
        end
        check("boot_no_ack", 64'(ackCount0 - ackStart), 64'd0);
        check("boot_done_booting", 64'(boot0), 64'd0);
        check("boot_done_addr", 64'(addr0), 64'd0);

        // Segment refills after boot
        for (int s = 0; s < 2; s++) begin
            fillReq0 = 1'b1;
            tick();
            check($sformatf("refill%0d_ack", s), 64'(fillAck0), 64'd1);
            check($sformatf("refill%0d_segment", s), 64'(seg0), 64'(2'b01 << s));
            check($sformatf("refill%0d_status", s), 64'(pioOut0), 64'd6);
            fillReq0 = 1'b0;
            tick();
            check($sformatf("refill%0d_ack_pulse", s), 64'(fillAck0), 64'd0);
            for (int j = 0; j < 128; j++) begin
                w = {16'h0, 16'(s * 128 + j), 16'hC3C3 ^ 16'(j)};
                sendWord(0, 2, w, 8'(s * 128 + j), (j == 127) ? 32'd7 : 32'd6);
            end
        end
        check("refill_wrap_segment", 64'(seg0), 64'd0);
        check("refill_wrap_addr", 64'(addr0), 64'd0);

        // Asynchronous reset while writing
        doReset();
        pio0 = 32'h0045_5A5A;
        tick();
        pio0 = 32'h0046_A5A5;
        tick();
        check("midwrite_wren_before", 64'(wren0), 64'd1);
        #2;
        reset_n = 1'b0;
        #1;
        checkResetValues0("async_reset");
        @(posedge clock);
        #1;
        reset_n = 1'b1;

        // 48-bit words, four segments
        doReset();
        check("cfg2_reset_segment", 64'(seg1), 64'd0);
        for (int i = 0; i < 256; i++) begin
            w = {16'(i * 7), 16'(~i), 16'(i + 16'h0100)};
            sendWord(1, 3, w, 8'(i), (i == 255) ? 32'd7 : 32'd6);
        end
        check("cfg2_boot_done", 64'(boot1), 64'd0);
        for (int s = 0; s < 4; s++) begin
            fillReq1 = 1'b1;
            tick();
            check($sformatf("cfg2_refill%0d_ack", s), 64'(fillAck1), 64'd1);
            check($sformatf("cfg2_refill%0d_segment", s), 64'(seg1), 64'(4'b0001 << s));
            fillReq1 = 1'b0;
            for (int j = 0; j < 64; j++) begin
                w = {16'(s), 16'(j), 16'hBEEF ^ 16'(j)};
                sendWord(1, 3, w, 8'(s * 64 + j), (j == 63) ? 32'd7 : 32'd6);
            end
        end
        check("cfg2_wrap_segment", 64'(seg1), 64'd0);
        check("cfg2_error", 64'(err1), 64'd0);

        $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
        $finish;
    end

endmodule
